// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - UART byte-stream loader for the instruction memory write port
//
// Assembles a big-endian 32-bit word stream, preceded by a 16-bit word count,
// and writes the words to consecutive instruction-memory addresses starting
// at 0. The CPU is held in reset while a load is in progress or has failed.
//
// Ports:
//   clock          system clock, all logic on posedge
//   reset          synchronous, active-high reset
//   start          one-cycle pulse that begins a load session
//   rx_data        received byte
//   rx_valid       one-cycle strobe qualifying rx_data
//   imem_we        instruction-memory write enable (one-cycle pulse)
//   imem_addr      word address for the write
//   imem_wdata     instruction word to write
//   cpu_hold       high while loading or in error; OR'd into the CPU reset
//   load_done      high after a successful load, until the next start
//   load_err       high after a failed load, until the next start
//   words_written  count of words committed in the current or last session

module imem_loader #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_written
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]      state;
  logic [1:0]      byte_cnt;
  logic [15:0]     n_words;
  logic [23:0]     shift;
  logic [TO_W-1:0] to_cnt;

  logic [15:0]     hdr_n;
  logic            hdr_too_big;
  logic [ADDR_W:0] ww_next;
  logic            last_commit;
  logic            timeout_hit;

  // Full count as it will be once the second header byte is latched.
  assign hdr_n       = {n_words[15:8], rx_data};
  assign hdr_too_big = 32'(hdr_n) > (32'd1 << ADDR_W);

  assign ww_next     = words_written + 1'b1;
  assign last_commit = imem_we && (32'(ww_next) == 32'(n_words));

  // The counter holds the number of idle cycles already elapsed, so the
  // idle cycle that would make it reach TIMEOUT is the one that errors out.
  assign timeout_hit = !rx_valid && (to_cnt == TO_W'(TIMEOUT - 1));

  assign cpu_hold  = (state == S_HDR) || (state == S_DATA) || (state == S_ERR);
  assign load_done = (state == S_DONE);
  assign load_err  = (state == S_ERR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      byte_cnt      <= 2'd0;
      n_words       <= 16'd0;
      shift         <= 24'd0;
      to_cnt        <= '0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= 32'd0;
      words_written <= '0;
    end else begin
      imem_we <= 1'b0;

      // A write is counted in the cycle its enable is visible.
      if (imem_we) begin
        words_written <= ww_next;
      end

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state         <= S_HDR;
            byte_cnt      <= 2'd0;
            to_cnt        <= '0;
            words_written <= '0;
          end
        end

        S_HDR: begin
          if (rx_valid) begin
            to_cnt <= '0;
            if (byte_cnt == 2'd0) begin
              n_words[15:8] <= rx_data;
              byte_cnt      <= 2'd1;
            end else begin
              n_words[7:0] <= rx_data;
              byte_cnt     <= 2'd0;
              if (hdr_n == 16'd0) begin
                state <= S_DONE;
              end else if (hdr_too_big) begin
                state <= S_ERR;
              end else begin
                state <= S_DATA;
              end
            end
          end else if (timeout_hit) begin
            state <= S_ERR;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_DATA: begin
          // The final commit ends the session; any trailing byte is dropped.
          if (last_commit) begin
            state <= S_DONE;
          end else if (rx_valid) begin
            to_cnt   <= '0;
            shift    <= {shift[15:0], rx_data};
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {shift, rx_data};
              imem_addr  <= words_written[ADDR_W-1:0];
            end
          end else if (timeout_hit) begin
            state <= S_ERR;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader

module tb_imem_loader;

  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_valid = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_written;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .cpu_hold      (cpu_hold),
    .load_done     (load_done),
    .load_err      (load_err),
    .words_written (words_written)
  );

  always #5 clock = ~clock;

  // Every write pulse must match the oldest expected write.
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%h required=no write", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data) begin
          failures++;
          $display("FAIL write addr=%0d data=%h required addr=%0d data=%h", imem_addr, imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) send_byte(w[31 - 8*b -: 8]);
  endtask

  task automatic push_write(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = a[ADDR_W-1:0];
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err, words_written} !== '0) begin
      failures++;
      $display("FAIL reset_values we=%b addr=%0d wdata=%h hold=%b done=%b err=%b ww=%0d required all 0",
               imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err, words_written);
    end
  endtask

  task automatic test_two_words();
    do_reset();
    pulse_start();
    checks++;
    if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL two_hdr_hold hold=%b done=%b required hold=1 done=0", cpu_hold, load_done);
    end
    push_write(0, 32'h24080005);
    push_write(1, 32'hAC080000);
    send_byte(8'h00); send_byte(8'h02);
    send_word(32'h24080005);
    send_word(32'hAC080000);
    checks++;
    if (imem_we !== 1'b1 || load_done !== 1'b0 || words_written !== 5'd1) begin
      failures++;
      $display("FAIL two_last_we we=%b done=%b ww=%0d required we=1 done=0 ww=1", imem_we, load_done, words_written);
    end
    tick(1);
    checks++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0 || words_written !== 5'd2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL two_done done=%b hold=%b ww=%0d pending=%0d required done=1 hold=0 ww=2 pending=0",
               load_done, cpu_hold, words_written, exp_q.size());
    end
    send_byte(8'h77);
    tick(2);
    checks++;
    if (load_done !== 1'b1 || words_written !== 5'd2) begin
      failures++;
      $display("FAIL done_ignores_rx done=%b ww=%0d required done=1 ww=2", load_done, words_written);
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    checks++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0 || words_written !== 5'd0) begin
      failures++;
      $display("FAIL zero_len done=%b hold=%b ww=%0d required done=1 hold=0 ww=0", load_done, cpu_hold, words_written);
    end
    tick(3);
  endtask

  task automatic test_oversize();
    do_reset();
    pulse_start();
    send_byte(8'h00); send_byte(8'h11);
    checks++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL oversize err=%b hold=%b done=%b required err=1 hold=1 done=0", load_err, cpu_hold, load_done);
    end
    pulse_start();
    checks++;
    if (load_err !== 1'b0 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL restart_after_err err=%b hold=%b required err=0 hold=1", load_err, cpu_hold);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB);
    tick(TIMEOUT - 1);
    checks++;
    if (load_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early err=%b required err=0", load_err);
    end
    tick(1);
    checks++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1 || words_written !== 5'd0) begin
      failures++;
      $display("FAIL timeout err=%b hold=%b ww=%0d required err=1 hold=1 ww=0", load_err, cpu_hold, words_written);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    do_reset();
    pulse_start();
    send_byte(8'h00); send_byte(8'h10);
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      push_write(w, d);
      send_word(d);
    end
    checks++;
    if (words_written !== 5'd15 || imem_we !== 1'b1 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL full_last_we ww=%0d we=%b done=%b required ww=15 we=1 done=0", words_written, imem_we, load_done);
    end
    tick(1);
    checks++;
    if (words_written !== 5'd16 || load_done !== 1'b1 || cpu_hold !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL full_done ww=%0d done=%b hold=%b pending=%0d required ww=16 done=1 hold=0 pending=0",
               words_written, load_done, cpu_hold, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    push_write(0, 32'h12345678);
    send_word(32'h12345678);
    tick(1);
    checks++;
    if (words_written !== 5'd1 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL mid_first_word ww=%0d hold=%b required ww=1 hold=1", words_written, cpu_hold);
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++;
    if ({imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err, words_written} !== '0) begin
      failures++;
      $display("FAIL mid_reset we=%b addr=%0d wdata=%h hold=%b done=%b err=%b ww=%0d required all 0",
               imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err, words_written);
    end
    send_byte(8'h55);
    tick(1);
    checks++;
    if (cpu_hold !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignores_rx hold=%b done=%b err=%b required all 0", cpu_hold, load_done, load_err);
    end
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    push_write(0, 32'hDEADBEEF);
    send_word(32'hDEADBEEF);
    tick(1);
    checks++;
    if (load_done !== 1'b1 || words_written !== 5'd1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL reload done=%b ww=%0d pending=%0d required done=1 ww=1 pending=0", load_done, words_written, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_len();
    test_oversize();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL writes_missing pending=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader: the write side of the program ROM that the fetch unit reads. It takes a byte stream from the UART receiver, assembles big-endian 32-bit instruction words and writes them sequentially into the instruction memory's second (write) port. While loading, it holds the CPU in reset, so fetch never reads a half-written image.

## Interface

Parameters:
- ADDR_W, 14: instruction-memory word-address width; depth = 2^ADDR_W words.
- TIMEOUT, 1_000_000: maximum clock cycles allowed between bytes while loading.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load session.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- imem_we  out  1  instruction-memory write enable (one-cycle pulse).
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  instruction word to write.
- cpu_hold  out  1  held high while loading or in error; OR'd into the CPU reset.
- load_done  out  1  level; high after a successful load, until the next start.
- load_err  out  1  level; high after a failed load, until the next start.
- words_written  out  ADDR_W+1  count of words committed in the current or last session.

## Operation

- Stream format:
  - Two header bytes give word count N (16-bit, MSB first).
  - N words follow, 4 bytes each, MSB first. Word k is written to address k.
- States: IDLE, HDR, DATA, DONE, ERR.
- IDLE / DONE / ERR:
  - rx_valid is ignored.
  - start → HDR. This clears byte_cnt, words_written, load_done, load_err and the timeout counter.
- HDR:
  - The first byte sets N[15:8]; the second sets N[7:0].
  - After the second byte:
    - N = 0 → DONE.
    - N > 2^ADDR_W → ERR.
    - Otherwise → DATA.
- DATA:
  - Each accepted byte shifts into a 32-bit shift register; byte_cnt counts 0..3 and wraps.
  - On the 4th byte, register imem_wdata and imem_addr = words_written[ADDR_W-1:0], then pulse imem_we.
  - words_written increments on the cycle imem_we is high.
  - When words_written reaches N (after the last write) → DONE.
- Timeout:
  - In HDR and DATA, a counter increments every cycle without rx_valid and clears on rx_valid.
  - When the counter reaches TIMEOUT → ERR. Already-written words stay in memory; words_written keeps its value.
- start while in HDR or DATA is ignored.
- If start and rx_valid occur in the same cycle in IDLE/DONE/ERR, start wins and the byte is discarded.
- Outputs by state:
  - cpu_hold = 1 in HDR, DATA, ERR; 0 in IDLE, DONE.
  - load_done = 1 only in DONE.
  - load_err = 1 only in ERR.
- Arithmetic:
  - words_written is ADDR_W+1 bits, so it can hold the full-depth value 2^ADDR_W without wrapping.
  - The N comparison is 16-bit against 2^ADDR_W, with zero-extension.

## Timing

- Reset values: state IDLE; imem_we 0; imem_addr 0; imem_wdata 0; cpu_hold 0; load_done 0; load_err 0; words_written 0; byte_cnt 0.
- Reset asserted mid-load: next cycle returns to IDLE with all reset values. Memory contents are not restored.
- Byte acceptance: rx_valid is sampled on posedge. Back-to-back rx_valid on every cycle must be accepted without loss.
- Write latency: imem_we is high in the cycle after the posedge that accepted the 4th byte. It lasts exactly one cycle, with addr and wdata stable in that cycle.
- DONE is entered in the same cycle as words_written becomes N. load_done and cpu_hold=0 are visible from that cycle.
- N = 0: DONE in the cycle after the posedge that accepts the 2nd header byte. No imem_we is ever asserted.
- Timeout: with no byte after acceptance at posedge t, ERR is visible at posedge t + TIMEOUT.
- No backpressure: the upstream UART is never stalled. Bytes arriving in IDLE/DONE/ERR are dropped.

## Test plan

- Load 2 words. Stimulus: start, then bytes 00 02 24 08 00 05 AC 08 00 00. Response: imem_we pulses at addr 0 with data 0x24080005, then at addr 1 with data 0xAC080000. Then load_done=1, cpu_hold=0, words_written=2.
- Zero-length load. Stimulus: start, then 00 00. Response: DONE, no write pulse, words_written=0.
- Oversize load, with ADDR_W=4. Stimulus: header 00 11 (N=17). Response: ERR, load_err=1, cpu_hold=1, no writes. A following start returns to HDR with load_err=0.
- Timeout, with TIMEOUT=16. Stimulus: header 00 01, then 2 data bytes, then silence. Response: ERR exactly 16 cycles after the last byte, words_written=0.
- Full depth with back-to-back bytes, ADDR_W=4, N=16, rx_valid every cycle. Response: 16 writes at addr 0..15, words_written=16 (no wrap), then DONE.
- Reset during DATA after 1 word. Response: IDLE next cycle, all outputs at reset values. A subsequent byte is ignored; a new start reloads correctly.
